eth_pcs_66_64_dec: RTL and testbench

//  Receive-side 64b/66b decoder of the 10GBASE-R PCS. Sits after descrambler/block-lock, before XGMII RX.

---
 rtl/eth_pcs_params.sv | 43 ++++
 rtl/eth_pcs_66_blk_classify.sv | 87 ++++++++
 rtl/eth_pcs_66_64_dec.sv | 123 ++++++++++++
 tb/tb_eth_pcs_66_64_dec.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/eth_pcs_params.sv
// Shared 10GBASE-R PCS constants: sync headers, block types, XGMII symbols and the
// receive-side state/class enumerations used by the 64b/66b decoder.
package eth_pcs_params;

    localparam int W_BYTE          = 8;
    localparam int W_SYNC          = 2;
    localparam int N_CHANNELS      = 4;
    localparam int N_TRANS_PER_BLK = 2;
    localparam int W_TRANS_PER_BLK = (N_TRANS_PER_BLK > 1) ? $clog2(N_TRANS_PER_BLK) : 1;
    localparam int W_DATA          = N_CHANNELS * W_BYTE;
    localparam int W_BLK_PLD       = 64;
    localparam int W_BLK_CTRL      = W_BLK_PLD / W_BYTE;

    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] C_TYPE  = 8'h1E;
    localparam logic [7:0] S0_TYPE = 8'h78;
    localparam logic [7:0] S4_TYPE = 8'h33;
    localparam logic [7:0] T0_TYPE = 8'h87;
    localparam logic [7:0] T1_TYPE = 8'h99;
    localparam logic [7:0] T2_TYPE = 8'hAA;
    localparam logic [7:0] T3_TYPE = 8'hB4;
    localparam logic [7:0] T4_TYPE = 8'hCC;
    localparam logic [7:0] T5_TYPE = 8'hD2;
    localparam logic [7:0] T6_TYPE = 8'hE1;
    localparam logic [7:0] T7_TYPE = 8'hFF;

    localparam logic [7:0] SYM_IDLE  = 8'h07;
    localparam logic [7:0] SYM_START = 8'hFB;
    localparam logic [7:0] SYM_TERM  = 8'hFD;
    localparam logic [7:0] SYM_ERR   = 8'hFE;

    localparam logic [6:0] CODE_IDLE = 7'h00;

    // Local-fault ordered set, repeated on every transfer while not decoding.
    localparam logic [N_CHANNELS-1:0] SEQ_LF_CTRL = 4'b0001;
    localparam logic [W_DATA-1:0]     SEQ_LF_DATA = 32'h0100009C;

    typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;
    typedef enum logic [2:0] {BLK_C, BLK_S, BLK_T, BLK_D, BLK_E} blk_class_t;

endpackage

// File: rtl/eth_pcs_66_blk_classify.sv
// Combinational classifier/decoder for one 66b block: sync header + 64b payload in,
// block class plus 8-lane XGMII ctrl/data out.
module eth_pcs_66_blk_classify
    import eth_pcs_params::*;
(
    input  logic [W_SYNC-1:0]     i_sync,
    input  logic [W_BLK_PLD-1:0]  i_pld,
    output blk_class_t            o_class,
    output logic [W_BLK_CTRL-1:0] o_ctrl,
    output logic [W_BLK_PLD-1:0]  o_data
);

    logic [7:0]  blk_type;
    logic [71:0] pld_ext;
    logic        codes_idle;
    logic        t_hit;
    logic [2:0]  t_n;
    logic [55:0] t_mask;

    assign blk_type = i_pld[7:0];
    assign pld_ext  = {8'h00, i_pld};
    // Everything above the n data bytes of a terminate block must be idle/zero.
    assign t_mask   = {56{1'b1}} << {t_n, 3'b000};

    always_comb begin
        codes_idle = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (i_pld[8 + 7*k +: 7] != CODE_IDLE) begin
                codes_idle = 1'b0;
            end
        end
    end

    always_comb begin
        t_hit = 1'b1;
        t_n   = 3'd0;
        case (blk_type)
            T0_TYPE: t_n = 3'd0;
            T1_TYPE: t_n = 3'd1;
            T2_TYPE: t_n = 3'd2;
            T3_TYPE: t_n = 3'd3;
            T4_TYPE: t_n = 3'd4;
            T5_TYPE: t_n = 3'd5;
            T6_TYPE: t_n = 3'd6;
            T7_TYPE: t_n = 3'd7;
            default: t_hit = 1'b0;
        endcase
    end

    always_comb begin
        o_class = BLK_E;
        o_ctrl  = '1;
        o_data  = {W_BLK_CTRL{SYM_ERR}};
        if (i_sync == SYNC_DATA) begin
            o_class = BLK_D;
            o_ctrl  = '0;
            o_data  = i_pld;
        end else if (i_sync == SYNC_CTRL) begin
            if (blk_type == C_TYPE && codes_idle) begin
                o_class = BLK_C;
                o_ctrl  = '1;
                o_data  = {W_BLK_CTRL{SYM_IDLE}};
            end else if (blk_type == S0_TYPE) begin
                o_class = BLK_S;
                o_ctrl  = 8'h01;
                o_data  = {i_pld[63:8], SYM_START};
            end else if (blk_type == S4_TYPE && i_pld[39:8] == 32'h0) begin
                o_class = BLK_S;
                o_ctrl  = 8'h1F;
                o_data  = {i_pld[63:40], SYM_START, {4{SYM_IDLE}}};
            end else if (t_hit && (i_pld[63:8] & t_mask) == 56'h0) begin
                o_class = BLK_T;
                o_ctrl  = 8'hFF << t_n;
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(t_n)) begin
                        o_data[8*k +: 8] = pld_ext[8*k + 8 +: 8];
                    end else if (k == int'(t_n)) begin
                        o_data[8*k +: 8] = SYM_TERM;
                    end else begin
                        o_data[8*k +: 8] = SYM_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/eth_pcs_66_64_dec.sv
// Receive-side 64b/66b decoder: buffers payload chunks, classifies each completed block,
// runs the receive state machine and replays the decoded block over the next block period.
module eth_pcs_66_64_dec
    import eth_pcs_params::*;
#(
    parameter int W_ERR_CNT = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_clk_en,
    input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
    input  logic                       i_blk_lock,
    input  logic [W_SYNC-1:0]          i_sync_data,
    input  logic [W_DATA-1:0]          i_pld_data,
    output logic [N_CHANNELS-1:0]      o_xgmii_ctrl,
    output logic [W_DATA-1:0]          o_xgmii_data,
    output logic [W_ERR_CNT-1:0]       o_err_cnt
);

    localparam logic [W_TRANS_PER_BLK-1:0] LAST_TRANS = W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1);

    logic [W_DATA-1:0]     buf_q      [N_TRANS_PER_BLK];
    logic [W_DATA-1:0]     buf_d      [N_TRANS_PER_BLK];
    logic [N_CHANNELS-1:0] blk_ctrl_q [N_TRANS_PER_BLK];
    logic [N_CHANNELS-1:0] blk_ctrl_d [N_TRANS_PER_BLK];
    logic [W_DATA-1:0]     blk_data_q [N_TRANS_PER_BLK];
    logic [W_DATA-1:0]     blk_data_d [N_TRANS_PER_BLK];
    rx_state_t             state_q, state_d;
    logic [W_ERR_CNT-1:0]  err_cnt_q, err_cnt_d;

    logic [W_BLK_PLD-1:0]  full_blk;
    blk_class_t            cls_class;
    logic [W_BLK_CTRL-1:0] cls_ctrl;
    logic [W_BLK_PLD-1:0]  cls_data;
    logic [W_BLK_CTRL-1:0] new_ctrl;
    logic [W_BLK_PLD-1:0]  new_data;

    // The chunk arriving on the decode transfer bypasses the buffer.
    generate
        for (genvar gi = 0; gi < N_TRANS_PER_BLK; gi++) begin : g_merge
            assign full_blk[gi*W_DATA +: W_DATA] =
                (i_trans_cnt == W_TRANS_PER_BLK'(gi)) ? i_pld_data : buf_q[gi];
        end
    endgenerate

    eth_pcs_66_blk_classify u_classify (
        .i_sync  (i_sync_data),
        .i_pld   (full_blk),
        .o_class (cls_class),
        .o_ctrl  (cls_ctrl),
        .o_data  (cls_data)
    );

    always_comb begin
        state_d    = state_q;
        err_cnt_d  = err_cnt_q;
        buf_d      = buf_q;
        blk_ctrl_d = blk_ctrl_q;
        blk_data_d = blk_data_q;
        new_ctrl   = cls_ctrl;
        new_data   = cls_data;
        if (i_clk_en) begin
            buf_d[i_trans_cnt] = i_pld_data;
            if (i_trans_cnt == LAST_TRANS) begin
                if (!i_blk_lock) begin
                    state_d = RX_INIT;
                end else begin
                    case (state_q)
                        RX_INIT, RX_C, RX_T:
                            state_d = (cls_class == BLK_C) ? RX_C :
                                      (cls_class == BLK_S) ? RX_D : RX_E;
                        RX_D:
                            state_d = (cls_class == BLK_D) ? RX_D :
                                      (cls_class == BLK_T) ? RX_T : RX_E;
                        RX_E:
                            state_d = (cls_class == BLK_C) ? RX_C :
                                      (cls_class == BLK_D) ? RX_D :
                                      (cls_class == BLK_T) ? RX_T : RX_E;
                        default: state_d = RX_INIT;
                    endcase
                end
                // The substituted output follows the state the block lands in.
                if (state_d == RX_E) begin
                    new_ctrl = '1;
                    new_data = {W_BLK_CTRL{SYM_ERR}};
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + W_ERR_CNT'(1);
                    end
                end else if (state_d == RX_INIT) begin
                    new_ctrl = {N_TRANS_PER_BLK{SEQ_LF_CTRL}};
                    new_data = {N_TRANS_PER_BLK{SEQ_LF_DATA}};
                end
                for (int t = 0; t < N_TRANS_PER_BLK; t++) begin
                    blk_ctrl_d[t] = new_ctrl[t*N_CHANNELS +: N_CHANNELS];
                    blk_data_d[t] = new_data[t*W_DATA +: W_DATA];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= RX_INIT;
            err_cnt_q <= '0;
            for (int t = 0; t < N_TRANS_PER_BLK; t++) begin
                buf_q[t]      <= '0;
                blk_ctrl_q[t] <= SEQ_LF_CTRL;
                blk_data_q[t] <= SEQ_LF_DATA;
            end
        end else begin
            state_q    <= state_d;
            err_cnt_q  <= err_cnt_d;
            buf_q      <= buf_d;
            blk_ctrl_q <= blk_ctrl_d;
            blk_data_q <= blk_data_d;
        end
    end

    assign o_xgmii_ctrl = blk_ctrl_q[i_trans_cnt];
    assign o_xgmii_data = blk_data_q[i_trans_cnt];
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_eth_pcs_66_64_dec.sv
// Scoreboard bench for eth_pcs_66_64_dec: directed 66b blocks are queued with their
// hand-derived decode; a negedge monitor checks the block replayed one period later.
module tb_eth_pcs_66_64_dec;
    import eth_pcs_params::*;

    localparam logic [63:0] PLD_C  = 64'h000000000000001E;
    localparam logic [63:0] IDLE_D = {8{8'h07}};
    localparam logic [63:0] ERR_D  = {8{8'hFE}};
    localparam logic [63:0] LF_D   = {2{32'h0100009C}};
    localparam logic [7:0]  LF_C   = 8'h11;
    localparam logic [63:0] PLD_S0 = 64'hD555555555555578;
    localparam logic [63:0] DEC_S0 = 64'hD5555555555555FB;
    localparam logic [63:0] PLD_D  = 64'h0123456789ABCDEF;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       clk_en = 1'b0;
    logic                       lock = 1'b0;
    logic [W_TRANS_PER_BLK-1:0] tc = '0;
    logic [W_SYNC-1:0]          sync = SYNC_CTRL;
    logic [W_DATA-1:0]          pld = '0;
    logic [N_CHANNELS-1:0]      o_ctrl;
    logic [W_DATA-1:0]          o_data;
    logic [7:0]                 o_err;

    typedef struct {
        string       name;
        logic [7:0]  ctrl;
        logic [63:0] data;
        logic [7:0]  err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_err = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    eth_pcs_66_64_dec #(.W_ERR_CNT(8)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_clk_en     (clk_en),
        .i_trans_cnt  (tc),
        .i_blk_lock   (lock),
        .i_sync_data  (sync),
        .i_pld_data   (pld),
        .o_xgmii_ctrl (o_ctrl),
        .o_xgmii_data (o_data),
        .o_err_cnt    (o_err)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   idx;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: got DUT output ctrl %h data %h required a queued block",
                         o_ctrl, o_data);
            end else begin
                e   = exp_q[0];
                idx = int'(tc);
                check({e.name, "_ctrl"}, 64'(o_ctrl), 64'(e.ctrl[4*idx +: 4]));
                check({e.name, "_data"}, 64'(o_data), 64'(e.data[32*idx +: 32]));
                check({e.name, "_err"},  64'(o_err),  64'(e.err));
                if (clk_en && tc == W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1)) begin
                    $display("blk %-12s ctrl %h data %h err %0d", e.name, e.ctrl, e.data, e.err);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One 66b block over two transfers; the expected decode is queued up front.
    task automatic send_block(input string nm, input logic [1:0] s, input logic [63:0] p,
                              input logic lk, input logic [7:0] ec, input logic [63:0] ed,
                              input bit is_e, input bit gap, input bit push);
        exp_t e;
        if (is_e) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
        if (push) begin
            e.name = nm;
            e.ctrl = ec;
            e.data = ed;
            e.err  = 8'(exp_err);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        clk_en = 1'b1; tc = '0; sync = s; pld = p[31:0]; lock = lk;
        if (gap) begin
            for (int g = 0; g < 3; g++) begin
                @(posedge clk); #1;
                clk_en = 1'b0;
                tc     = W_TRANS_PER_BLK'(g % 2 == 0 ? 1 : 0);
                pld    = 32'hDEADBEEF;
            end
        end
        @(posedge clk); #1;
        clk_en = 1'b1; tc = W_TRANS_PER_BLK'(1); pld = p[63:32];
    endtask

    initial begin
        exp_t lf0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lock  = 1'b1;
        lf0.name = "reset_LF"; lf0.ctrl = LF_C; lf0.data = LF_D; lf0.err = 8'd0;
        exp_q.push_back(lf0);
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++)
            send_block("C_idle", SYNC_CTRL, PLD_C, 1'b1, 8'hFF, IDLE_D, 0, 0, 1);
        send_block("S0",       SYNC_CTRL, PLD_S0, 1'b1, 8'h01, DEC_S0, 0, 0, 1);
        send_block("D_pass",   SYNC_DATA, PLD_D, 1'b1, 8'h00, PLD_D, 0, 0, 1);
        send_block("T3",       SYNC_CTRL, 64'h00000000CCBBAAB4, 1'b1, 8'hF8, 64'h07070707FDCCBBAA, 0, 0, 1);
        send_block("C_after_T", SYNC_CTRL, PLD_C, 1'b1, 8'hFF, IDLE_D, 0, 0, 1);
        send_block("D_after_C", SYNC_DATA, PLD_D, 1'b1, 8'hFF, ERR_D, 1, 0, 1);
        send_block("C_recover", SYNC_CTRL, PLD_C, 1'b1, 8'hFF, IDLE_D, 0, 0, 1);
        send_block("sync11",   2'b11, PLD_C, 1'b1, 8'hFF, ERR_D, 1, 0, 1);
        send_block("C_recov2", SYNC_CTRL, PLD_C, 1'b1, 8'hFF, IDLE_D, 0, 0, 1);
        send_block("S0_b",     SYNC_CTRL, PLD_S0, 1'b1, 8'h01, DEC_S0, 0, 0, 1);
        send_block("D_b",      SYNC_DATA, PLD_D, 1'b1, 8'h00, PLD_D, 0, 0, 1);
        send_block("D_unlock", SYNC_DATA, PLD_D, 1'b0, LF_C, LF_D, 0, 0, 1);
        send_block("S4_relock", SYNC_CTRL, 64'h3322110000000033, 1'b1, 8'h1F, 64'h332211FB07070707, 0, 0, 1);
        send_block("T0",       SYNC_CTRL, 64'h0000000000000087, 1'b1, 8'hFF, 64'h07070707070707FD, 0, 0, 1);
        send_block("C_clkgap", SYNC_CTRL, PLD_C, 1'b1, 8'hFF, IDLE_D, 0, 1, 1);
        send_block("S0_c",     SYNC_CTRL, PLD_S0, 1'b1, 8'h01, DEC_S0, 0, 0, 1);
        send_block("T7",       SYNC_CTRL, 64'h77665544332211FF, 1'b1, 8'h80, 64'hFD77665544332211, 0, 0, 1);
        send_block("S0_d",     SYNC_CTRL, PLD_S0, 1'b1, 8'h01, DEC_S0, 0, 0, 1);
        send_block("T3_bad",   SYNC_CTRL, 64'h80000000CCBBAAB4, 1'b1, 8'hFF, ERR_D, 1, 0, 1);
        send_block("C_recov3", SYNC_CTRL, PLD_C, 1'b1, 8'hFF, IDLE_D, 0, 0, 1);
        for (int i = 0; i < 260; i++)
            send_block("sync11_sat", 2'b11, PLD_C, 1'b1, 8'hFF, ERR_D, 1, 0, 1);
        send_block("C_post_sat", SYNC_CTRL, PLD_C, 1'b1, 8'hFF, IDLE_D, 0, 0, 1);
        send_block("flush",    SYNC_CTRL, PLD_C, 1'b1, 8'hFF, IDLE_D, 0, 0, 0);

        @(negedge clk); #1;
        mon_en = 1'b0;
        clk_en = 1'b0;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Async reset in the middle of a block: LF must appear without a clock edge.
        @(posedge clk); #1;
        clk_en = 1'b1; tc = '0; pld = PLD_C[31:0];
        check("pre_reset_idle", 64'(o_data), 64'h07070707);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctrl0", 64'(o_ctrl), 64'(SEQ_LF_CTRL));
        check("async_rst_data0", 64'(o_data), 64'(SEQ_LF_DATA));
        check("async_rst_err",   64'(o_err), 64'd0);
        tc = W_TRANS_PER_BLK'(1);
        #1;
        check("async_rst_ctrl1", 64'(o_ctrl), 64'(SEQ_LF_CTRL));
        check("async_rst_data1", 64'(o_data), 64'(SEQ_LF_DATA));
        @(negedge clk);
        rst_n = 1'b1;
        clk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
